// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU display scanner: FSM states, select codes,
// digit indices, the registered output bundle and the nibble/select decode helpers.
package alu_disp_pkg;

   localparam int unsigned SEL_W  = 3;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned DIG_W  = 2;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      BLANK  = 2'd1,
      HOLD   = 2'd2,
      SCAN   = 2'd3
   } disp_state_e;

   localparam logic [SEL_W-1:0] SEL_BLANK0 = SEL_W'(4);
   localparam logic [SEL_W-1:0] SEL_BLANK1 = SEL_W'(5);
   localparam logic [SEL_W-1:0] SEL_HOLD   = SEL_W'(6);
   localparam logic [SEL_W-1:0] SEL_SCAN   = SEL_W'(7);

   localparam logic [DIG_W-1:0] DIG_F_LO  = DIG_W'(0);
   localparam logic [DIG_W-1:0] DIG_F_HI  = DIG_W'(1);
   localparam logic [DIG_W-1:0] DIG_FL_LO = DIG_W'(2);
   localparam logic [DIG_W-1:0] DIG_FL_HI = DIG_W'(3);

   typedef struct packed {
      logic [NIB_W-1:0] nibble;
      logic             dp;
      logic             blank;
      logic [DIG_W-1:0] digit_idx;
   } disp_out_t;

   // Values 0..3 pick a digit directly; the upper codes select the special modes.
   function automatic disp_state_e sel_to_state(input logic [SEL_W-1:0] sel);
      disp_state_e st;
      st = MANUAL;
      if (sel == SEL_BLANK0 || sel == SEL_BLANK1) st = BLANK;
      else if (sel == SEL_HOLD)                   st = HOLD;
      else if (sel == SEL_SCAN)                   st = SCAN;
      return st;
   endfunction

   function automatic logic [NIB_W-1:0] digit_mux(input logic [DIG_W-1:0]  dig,
                                                 input logic [DATA_W-1:0] f_v,
                                                 input logic [DATA_W-1:0] flags_v);
      logic [NIB_W-1:0] nib;
      case (dig)
         DIG_F_LO:  nib = f_v[3:0];
         DIG_F_HI:  nib = f_v[7:4];
         DIG_FL_LO: nib = flags_v[3:0];
         default:   nib = flags_v[7:4];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/alu_disp_prescaler.sv
// Free-running scan prescaler: tick marks the all-ones (wrap) cycle while run is high.
module alu_disp_prescaler #(
   parameter int unsigned W = 16
) (
   input  logic clk,
   input  logic rstb,
   input  logic ena,
   input  logic run,
   input  logic clr,
   output logic tick
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (run) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)    cnt_q <= '0;
      else if (ena) cnt_q <= cnt_d;
   end

   assign tick = run && (cnt_q == {W{1'b1}});

endmodule

// File: rtl/alu_display_scanner.sv
// Selects which ALU result/flag nibble drives the shared 7-seg decoder (manual, blank, hold, scan).
// Optional carry blink on c_out1 is enabled by defining ALU_DISP_CARRY_BLINK_EN.
module alu_display_scanner
   import alu_disp_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              ena,
   input  logic [DATA_W-1:0] f,
   input  logic [DATA_W-1:0] flags,
   input  logic [SEL_W-1:0]  sel,
   output logic [NIB_W-1:0]  nibble,
   output logic              dp,
   output logic              blank,
   output logic [DIG_W-1:0]  digit_idx
);

   disp_state_e       state_q, state_d;
   logic [DATA_W-1:0] f_q, f_d;
   logic [DATA_W-1:0] flags_q, flags_d;
   disp_out_t         out_q, out_d;
   logic [DIG_W-1:0]  digit_d;
   logic              enter_scan;
   logic              presc_run;
   logic              presc_clr;
   logic              presc_tick;
`ifdef ALU_DISP_CARRY_BLINK_EN
   logic              blink_q, blink_d;
`endif

   alu_disp_prescaler #(
      .W (PRESCALE_W)
   ) u_presc (
      .clk  (clk),
      .rstb (rstb),
      .ena  (ena),
      .run  (presc_run),
      .clr  (presc_clr),
      .tick (presc_tick)
   );

   // Next state, shadow capture, prescaler control and output mux.
   always_comb begin
      state_d    = sel_to_state(sel);
      f_d        = f_q;
      flags_d    = flags_q;
      enter_scan = (state_d == SCAN) && (state_q != SCAN);
      digit_d    = out_q.digit_idx;

      if (state_d != HOLD) begin
         f_d     = f;
         flags_d = flags;
      end

`ifdef ALU_DISP_CARRY_BLINK_EN
      presc_clr = (state_d == BLANK) || enter_scan ||
                  ((state_d == MANUAL) && (state_q != MANUAL));
      presc_run = (state_d == state_q) && ((state_d == SCAN) || (state_d == MANUAL));
`else
      presc_clr = (state_d == BLANK) || (state_d == MANUAL) || enter_scan;
      presc_run = (state_d == SCAN) && (state_q == SCAN);
`endif

      case (state_d)
         MANUAL:  digit_d = sel[DIG_W-1:0];
         SCAN: begin
            if (enter_scan)      digit_d = DIG_F_LO;
            else if (presc_tick) digit_d = out_q.digit_idx + DIG_W'(1);
         end
         default: digit_d = out_q.digit_idx;
      endcase

      out_d.digit_idx = digit_d;
      out_d.dp        = digit_d[0];
      out_d.nibble    = (state_d == BLANK) ? '0 : digit_mux(digit_d, f_q, flags_q);
      out_d.blank     = (state_d == BLANK);

`ifdef ALU_DISP_CARRY_BLINK_EN
      // Phase flips once per full scan round (or per prescaler wrap in manual), cleared with c_out1.
      blink_d = blink_q;
      if (!flags_q[3]) begin
         blink_d = 1'b0;
      end else if (presc_tick &&
                   ((state_d == MANUAL) ||
                    ((state_d == SCAN) && (out_q.digit_idx == DIG_FL_HI)))) begin
         blink_d = ~blink_q;
      end
      out_d.blank = (state_d == BLANK) || blink_d;
`endif
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q         <= MANUAL;
         f_q             <= '0;
         flags_q         <= '0;
         out_q.nibble    <= '0;
         out_q.dp        <= 1'b0;
         out_q.blank     <= 1'b1;
         out_q.digit_idx <= DIG_F_LO;
      end else if (ena) begin
         state_q <= state_d;
         f_q     <= f_d;
         flags_q <= flags_d;
         out_q   <= out_d;
      end
   end

`ifdef ALU_DISP_CARRY_BLINK_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)    blink_q <= 1'b0;
      else if (ena) blink_q <= blink_d;
   end
`endif

   assign nibble    = out_q.nibble;
   assign dp        = out_q.dp;
   assign blank     = out_q.blank;
   assign digit_idx = out_q.digit_idx;

endmodule

// File: tb/tb_alu_display_scanner.sv
// Self-checking bench for alu_display_scanner: directed scenarios plus randomized
// stimulus against a cycle-count based reference model.
module tb_alu_display_scanner;

   localparam int unsigned PW   = 2;
   localparam int unsigned STEP = 1 << PW;

   localparam int M_MAN   = 0;
   localparam int M_BLANK = 1;
   localparam int M_HOLD  = 2;
   localparam int M_SCAN  = 3;

   logic       clk = 1'b0;
   logic       rstb;
   logic       ena;
   logic [7:0] f;
   logic [7:0] flags;
   logic [2:0] sel;
   logic [3:0] nibble;
   logic       dp;
   logic       blank;
   logic [1:0] digit_idx;

   int checks = 0;
   int errors = 0;

   // Reference model state: mode, enabled cycles spent in the current mode, shown digit, shadows.
   int         m_mode;
   int         m_cnt;
   int         m_digit;
   logic [7:0] m_f;
   logic [7:0] m_fl;
   bit         m_blink;
   logic [3:0] e_nib;
   logic       e_dp;
   logic       e_blank;
   logic [1:0] e_digit;

   logic [3:0] scan_nib [4];

   alu_display_scanner #(
      .PRESCALE_W (PW)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .ena       (ena),
      .f         (f),
      .flags     (flags),
      .sel       (sel),
      .nibble    (nibble),
      .dp        (dp),
      .blank     (blank),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int mode_of(input logic [2:0] s);
      if (s < 3'd4)  return M_MAN;
      if (s == 3'd6) return M_HOLD;
      if (s == 3'd7) return M_SCAN;
      return M_BLANK;
   endfunction

   // Digits 0..3 are simply the four nibbles of {flags, f}.
   function automatic logic [3:0] pick(input int d, input logic [7:0] fv, input logic [7:0] fl);
      logic [15:0] both;
      both = {fl, fv};
      return both[d*4 +: 4];
   endfunction

   task automatic model_reset();
      m_mode  = M_MAN;
      m_cnt   = 0;
      m_digit = 0;
      m_f     = 8'h00;
      m_fl    = 8'h00;
      m_blink = 1'b0;
      e_nib   = 4'h0;
      e_dp    = 1'b0;
      e_blank = 1'b1;
      e_digit = 2'd0;
   endtask

   task automatic model_clock();
      int nm;
      bit toggle;
      nm     = mode_of(sel);
      toggle = 1'b0;
      case (nm)
         M_MAN: begin
            if (m_mode == M_MAN) begin
               m_cnt++;
               toggle = (m_cnt % STEP) == 0;
            end else begin
               m_cnt = 0;
            end
            m_digit = int'(sel[1:0]);
         end
         M_BLANK: m_cnt = 0;
         M_SCAN: begin
            if (m_mode == M_SCAN) begin
               m_cnt++;
               toggle = (m_cnt % (4 * STEP)) == 0;
            end else begin
               m_cnt = 0;
            end
            m_digit = (m_cnt / STEP) % 4;
         end
         default: ;
      endcase
`ifdef ALU_DISP_CARRY_BLINK_EN
      if (!m_fl[3])    m_blink = 1'b0;
      else if (toggle) m_blink = !m_blink;
`endif
      e_digit = 2'(m_digit);
      e_dp    = e_digit[0];
      e_nib   = (nm == M_BLANK) ? 4'h0 : pick(m_digit, m_f, m_fl);
      e_blank = (nm == M_BLANK) || (m_blink && m_fl[3]);
      if (nm != M_HOLD) begin
         m_f  = f;
         m_fl = flags;
      end
      m_mode = nm;
   endtask

   task automatic tick_chk();
      @(posedge clk);
      if (ena) model_clock();
      @(negedge clk);
      check("nibble", 8'(nibble), 8'(e_nib));
      check("dp", 8'(dp), 8'(e_dp));
      check("blank", 8'(blank), 8'(e_blank));
      check("digit_idx", 8'(digit_idx), 8'(e_digit));
   endtask

   // Assert reset between clock edges and verify outputs clear without any edge.
   task automatic async_reset(input logic [2:0] s_during);
      @(negedge clk);
      #1;
      rstb = 1'b0;
      sel  = s_during;
      #1;
      model_reset();
      check("rst_nibble", 8'(nibble), 8'h0);
      check("rst_dp", 8'(dp), 8'h0);
      check("rst_blank", 8'(blank), 8'h1);
      check("rst_digit", 8'(digit_idx), 8'h0);
      @(negedge clk);
      #1;
      rstb = 1'b1;
   endtask

   initial begin
      int hold_left;
      scan_nib = '{4'hC, 4'h3, 4'h6, 4'h9};
      rstb  = 1'b0;
      ena   = 1'b1;
      f     = 8'h00;
      flags = 8'h00;
      sel   = 3'd0;
      model_reset();
      async_reset(3'd0);

      // Manual digit selection
      f = 8'hA5;
      tick_chk();
      tick_chk();
      check("t1_nib_lo", 8'(nibble), 8'h5);
      check("t1_dp_lo", 8'(dp), 8'h0);
      check("t1_blank", 8'(blank), 8'h0);
      sel = 3'd1;
      tick_chk();
      check("t1_nib_hi", 8'(nibble), 8'hA);
      check("t1_dp_hi", 8'(dp), 8'h1);

      // Scan round
      f     = 8'h3C;
      flags = 8'h96;
      tick_chk();
      sel = 3'd7;
      for (int k = 0; k < 20; k++) begin
         tick_chk();
         check("t2_digit", 8'(digit_idx), 8'((k / 4) % 4));
         check("t2_nib", 8'(nibble), 8'(scan_nib[(k / 4) % 4]));
         check("t2_dp", 8'(dp), 8'((k / 4) % 2));
      end

      // Freeze at digit 2
      for (int i = 0; i < 16 && e_digit != 2'd2; i++) tick_chk();
      check("t3_at2", 8'(digit_idx), 8'h2);
      sel = 3'd6;
      tick_chk();
      flags = 8'h00;
      for (int i = 0; i < 5; i++) tick_chk();
      check("t3_hold_nib", 8'(nibble), 8'h6);
      check("t3_hold_dig", 8'(digit_idx), 8'h2);
      sel = 3'd7;
      tick_chk();
      check("t3_restart", 8'(digit_idx), 8'h0);

      // Blank, then clock enable low
      sel = 3'd4;
      tick_chk();
      check("t4_blank", 8'(blank), 8'h1);
      check("t4_nib", 8'(nibble), 8'h0);
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sel = 3'($urandom_range(0, 7));
         f   = 8'($urandom);
         tick_chk();
         check("t4_ena_blank", 8'(blank), 8'h1);
         check("t4_ena_nib", 8'(nibble), 8'h0);
      end
      ena = 1'b1;

      // Reset mid-scan at digit 3, release into manual
      sel = 3'd7;
      for (int i = 0; i < 24 && !(m_mode == M_SCAN && e_digit == 2'd3); i++) tick_chk();
      check("t5_at3", 8'(digit_idx), 8'h3);
      async_reset(3'd2);
      tick_chk();
      check("t5_manual", 8'(digit_idx), 8'h2);
      check("t5_unblank", 8'(blank), 8'h0);

      // Carry flag during scan
      flags = 8'h08;
      sel   = 3'd7;
      for (int i = 0; i < 40; i++) tick_chk();
      flags = 8'h00;
      for (int i = 0; i < 20; i++) tick_chk();
      check("t6_noblink", 8'(blank), 8'h0);

      // Randomized traffic
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold_left == 0) begin
            sel       = 3'($urandom_range(0, 7));
            hold_left = $urandom_range(1, 48);
         end
         hold_left--;
         if ($urandom_range(0, 3) == 0) f = 8'($urandom);
         if ($urandom_range(0, 5) == 0) flags = 8'($urandom);
         ena = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 299) == 0) async_reset(3'($urandom_range(0, 7)));
         tick_chk();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
